// File: rtl/e_muldiv.sv
// E-stage multiply/divide unit: decodes HI/LO instructions, holds HI/LO and
// models multi-cycle mult/div latency with a busy counter.
module e_muldiv #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        start,
    output logic        busy,
    output logic [31:0] mdOut,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t         r_state;
    logic           r_busy;
    logic [CW-1:0]  r_cnt;
    logic [31:0]    r_hi;
    logic [31:0]    r_lo;
    logic [31:0]    r_pendHi;
    logic [31:0]    r_pendLo;
    logic           r_divZero;

    logic           w_rtype;
    logic [5:0]     w_fn;
    logic           w_mfhi, w_mthi, w_mflo, w_mtlo;
    logic           w_mult, w_multu, w_div, w_divu;
    logic           w_isMul, w_isDiv;
    logic           w_unused;

    assign w_rtype  = (instr[31:26] == 6'd0);
    assign w_fn     = instr[5:0];
    assign w_unused = ^instr[25:6];

    assign w_mfhi  = w_rtype && (w_fn == F_MFHI);
    assign w_mthi  = w_rtype && (w_fn == F_MTHI);
    assign w_mflo  = w_rtype && (w_fn == F_MFLO);
    assign w_mtlo  = w_rtype && (w_fn == F_MTLO);
    assign w_mult  = w_rtype && (w_fn == F_MULT);
    assign w_multu = w_rtype && (w_fn == F_MULTU);
    assign w_div   = w_rtype && (w_fn == F_DIV);
    assign w_divu  = w_rtype && (w_fn == F_DIVU);
    assign w_isMul = w_mult | w_multu;
    assign w_isDiv = w_div | w_divu;

    assign start = (w_isMul | w_isDiv) & ~r_busy;
    assign busy  = r_busy;
    assign hi    = r_hi;
    assign lo    = r_lo;

    always_comb begin
        mdOut = '0;
        if (w_mfhi)
            mdOut = r_hi;
        else if (w_mflo)
            mdOut = r_lo;
    end

    // Products
    logic [63:0] w_prodS;
    logic [63:0] w_prodU;

    assign w_prodS = $signed({{32{srcA[31]}}, srcA}) * $signed({{32{srcB[31]}}, srcB});
    assign w_prodU = {32'd0, srcA} * {32'd0, srcB};

    // Quotients/remainders; a zero divisor is replaced so the datapath stays
    // defined, the result is discarded via r_divZero anyway.
    logic        w_bZero;
    logic [31:0] w_bSafe;
    logic [31:0] w_uq, w_ur;
    logic [31:0] w_magA, w_magB;
    logic [31:0] w_mq, w_mr;
    logic [31:0] w_sq, w_sr;

    assign w_bZero = (srcB == 32'd0);
    assign w_bSafe = w_bZero ? 32'd1 : srcB;
    assign w_uq    = srcA / w_bSafe;
    assign w_ur    = srcA % w_bSafe;

    // Signed divide on magnitudes; 0x80000000 / -1 wraps to 0x80000000 rem 0
    // naturally through the two's-complement negation.
    assign w_magA = srcA[31] ? (~srcA + 32'd1) : srcA;
    assign w_magB = w_bSafe[31] ? (~w_bSafe + 32'd1) : w_bSafe;
    assign w_mq   = w_magA / w_magB;
    assign w_mr   = w_magA % w_magB;
    assign w_sq   = (srcA[31] ^ w_bSafe[31]) ? (~w_mq + 32'd1) : w_mq;
    assign w_sr   = srcA[31] ? (~w_mr + 32'd1) : w_mr;

    logic [31:0] w_resHi;
    logic [31:0] w_resLo;

    always_comb begin
        w_resHi = '0;
        w_resLo = '0;
        if (w_mult) begin
            w_resHi = w_prodS[63:32];
            w_resLo = w_prodS[31:0];
        end else if (w_multu) begin
            w_resHi = w_prodU[63:32];
            w_resLo = w_prodU[31:0];
        end else if (w_div) begin
            w_resHi = w_sr;
            w_resLo = w_sq;
        end else if (w_divu) begin
            w_resHi = w_ur;
            w_resLo = w_uq;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pendHi  <= '0;
            r_pendLo  <= '0;
            r_divZero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pendHi  <= w_resHi;
                        r_pendLo  <= w_resLo;
                        r_divZero <= w_isDiv & w_bZero;
                        r_cnt     <= w_isDiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        r_busy    <= 1'b1;
                        r_state   <= S_BUSY;
                    end else begin
                        if (w_mthi)
                            r_hi <= srcA;
                        if (w_mtlo)
                            r_lo <= srcA;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == CW'(1)) begin
                        if (!r_divZero) begin
                            r_hi <= r_pendHi;
                            r_lo <= r_pendLo;
                        end
                        r_divZero <= 1'b0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_e_muldiv.sv
// Directed bench for e_muldiv: mult/multu/div/divu results and latency,
// divide-by-zero, mthi/mtlo/mfhi/mflo, stall behaviour and mid-op reset.
module tb_e_muldiv;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        start;
    logic        busy;
    logic [31:0] mdOut;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned checks = 0;
    int unsigned errors = 0;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    e_muldiv #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .instr (instr),
        .srcA  (srcA),
        .srcB  (srcB),
        .start (start),
        .busy  (busy),
        .mdOut (mdOut),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [5:0] fn);
        return {26'd0, fn};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one mult/div, watch n busy cycles with HI/LO held, then check results.
    // With stall=1 a second mult sits in E for the whole busy window.
    task automatic run_op(input string tag, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b, input int unsigned n,
                          input logic [31:0] eh, input logic [31:0] el,
                          input logic [31:0] oh, input logic [31:0] ol, input bit stall);
        tick();
        instr = enc(fn);
        srcA  = a;
        srcB  = b;
        #1;
        chk({tag, "_start"}, {31'd0, start}, 32'd1);
        chk({tag, "_busy0"}, {31'd0, busy}, 32'd0);
        tick();
        instr = stall ? enc(F_MULT) : 32'd0;
        srcA  = 32'd7;
        srcB  = 32'd7;
        for (int unsigned i = 0; i < n; i++) begin
            #1;
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_nostart"}, {31'd0, start}, 32'd0);
            chk({tag, "_hold_hi"}, hi, oh);
            chk({tag, "_hold_lo"}, lo, ol);
            tick();
        end
        chk({tag, "_b2b_start"}, {31'd0, start}, {31'd0, stall});
        instr = enc(F_MFHI);
        #1;
        chk({tag, "_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
        chk({tag, "_mfhi"}, mdOut, eh);
        instr = enc(F_MFLO);
        #1;
        chk({tag, "_mflo"}, mdOut, el);
        instr = 32'd0;
    endtask

    initial begin
        reset = 1'b1;
        instr = 32'd0;
        srcA  = 32'd0;
        srcB  = 32'd0;
        tick();
        tick();
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mdout", mdOut, 32'd0);
        reset = 1'b0;

        run_op("mult", F_MULT, 32'hFFFFFFFF, 32'd2, 5,
               32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 32'd0, 1'b0);
        run_op("multu", F_MULTU, 32'hFFFFFFFF, 32'd2, 5,
               32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        run_op("div", F_DIV, 32'hFFFFFFF9, 32'd2, 10,
               32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000001, 32'hFFFFFFFE, 1'b0);
        run_op("divovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 10,
               32'h00000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("divu", F_DIVU, 32'd100, 32'd7, 10,
               32'd2, 32'd14, 32'h00000000, 32'h80000000, 1'b0);

        // Preset HI/LO, then divide by zero must leave them alone
        tick();
        instr = enc(F_MTHI);
        srcA  = 32'h11;
        tick();
        instr = enc(F_MFHI);
        #1;
        chk("mthi_11", mdOut, 32'h11);
        instr = enc(F_MTLO);
        srcA  = 32'h22;
        tick();
        instr = enc(F_MFLO);
        #1;
        chk("mtlo_22", mdOut, 32'h22);
        instr = 32'd0;
        run_op("divz", F_DIVU, 32'd5, 32'd0, 10,
               32'h11, 32'h22, 32'h11, 32'h22, 1'b0);

        tick();
        instr = enc(F_MTHI);
        srcA  = 32'hDEADBEEF;
        tick();
        instr = enc(F_MFHI);
        #1;
        chk("mthi_dead", mdOut, 32'hDEADBEEF);
        chk("mthi_lo_kept", lo, 32'h22);
        instr = 32'd0;

        run_op("stall", F_MULT, 32'd3, 32'd4, 5,
               32'd0, 32'd12, 32'hDEADBEEF, 32'h22, 1'b1);

        // Reset in the 3rd busy cycle of a div
        tick();
        instr = enc(F_DIV);
        srcA  = 32'd100;
        srcB  = 32'd7;
        #1;
        chk("rdiv_start", {31'd0, start}, 32'd1);
        tick();
        instr = 32'd0;
        tick();
        tick();
        chk("rdiv_busy3", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rdiv_busy", {31'd0, busy}, 32'd0);
        chk("rdiv_hi", hi, 32'd0);
        chk("rdiv_lo", lo, 32'd0);
        for (int unsigned i = 0; i < 12; i++) begin
            tick();
            chk("rdiv_idle", {31'd0, busy}, 32'd0);
        end
        chk("rdiv_nowb_hi", hi, 32'd0);
        chk("rdiv_nowb_lo", lo, 32'd0);

        // mthi/mtlo issued while busy must be dropped
        tick();
        instr = enc(F_MULT);
        srcA  = 32'd2;
        srcB  = 32'd3;
        tick();
        instr = enc(F_MTLO);
        srcA  = 32'h55;
        tick();
        instr = 32'd0;
        for (int unsigned i = 0; i < 4; i++)
            tick();
        chk("mtlo_busy_lo", lo, 32'd6);
        chk("mtlo_busy_hi", hi, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
